// File: rtl/itype_pkg.sv
// Shared opcodes, FSM state codes, instruction field positions and decode helpers
// for the I-type issue unit.
package itype_pkg;

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // LUI pre-shifts so the ALU only has to pass the upper half through.
  function automatic logic [31:0] extendImm(input logic [5:0] op, input logic [15:0] imm);
    case (op)
      OP_ANDI, OP_ORI: extendImm = {16'h0000, imm};
      OP_LUI:          extendImm = {imm, 16'h0000};
      default:         extendImm = {{16{imm[15]}}, imm};
    endcase
  endfunction

  function automatic logic writesRt(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: writesRt = 1'b1;
      default: writesRt = 1'b0;
    endcase
  endfunction

  function automatic logic isBranch(input logic [5:0] op);
    isBranch = (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/itype_regfile.sv
// 32x32 register file: two combinational read ports plus a debug read, one write port.
// Register 0 is hardwired to zero; synchronous reset clears all entries.
module itype_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rdAddrA,
  output logic [31:0] rdDataA,
  input  logic [4:0]  rdAddrB,
  output logic [31:0] rdDataB,
  input  logic [4:0]  dbgAddr,
  output logic [31:0] dbgData,
  input  logic        wrEn,
  input  logic [4:0]  wrAddr,
  input  logic [31:0] wrData
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wrEn && (wrAddr != 5'd0)) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdDataA = (rdAddrA == 5'd0) ? 32'h0 : mem[rdAddrA];
  assign rdDataB = (rdAddrB == 5'd0) ? 32'h0 : mem[rdAddrB];
  assign dbgData = (dbgAddr == 5'd0) ? 32'h0 : mem[dbgAddr];

endmodule

// File: rtl/itype_issue_unit.sv
// I-type issue/writeback around an external combinational ALU: IDLE->READ->EXEC->WB, done 3 cycles
// after accept, one instruction per 4 cycles, instr_ready only in IDLE. Optional OVERFLOW_TRAP_EN adds trap.
module itype_issue_unit
  import itype_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic [31:0] alu_imm,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        done,
  output logic        branch_valid,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        illegal,
`ifdef OVERFLOW_TRAP_EN
  output logic        trap,
`endif
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [1:0]  state;
  logic [31:0] instrQ;
  logic [31:0] pcQ;
  logic [31:0] resultQ;
  logic        zeroQ;
  logic [5:0]  op;
  logic [4:0]  rsIdx;
  logic [4:0]  rtIdx;
  logic [15:0] imm;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        wrEn;
  logic        suppressWr;

  assign op    = instrQ[OP_HI:OP_LO];
  assign rsIdx = instrQ[RS_HI:RS_LO];
  assign rtIdx = instrQ[RT_HI:RT_LO];
  assign imm   = instrQ[IMM_HI:IMM_LO];

  assign instr_ready = (state == IDLE);

`ifdef OVERFLOW_TRAP_EN
  logic overflowQ;
  assign suppressWr = (op == OP_ADDI) && overflowQ;
`else
  assign suppressWr = 1'b0;
`endif

  assign wrEn = (state == WB) && writesRt(op) && !suppressWr;

  itype_regfile uRegfile (
    .clk     (clk),
    .rst     (rst),
    .rdAddrA (rsIdx),
    .rdDataA (rsData),
    .rdAddrB (rtIdx),
    .rdDataB (rtData),
    .dbgAddr (dbg_addr),
    .dbgData (dbg_data),
    .wrEn    (wrEn),
    .wrAddr  (rtIdx),
    .wrData  (resultQ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      instrQ        <= '0;
      pcQ           <= '0;
      resultQ       <= '0;
      zeroQ         <= 1'b0;
      alu_opcode    <= '0;
      alu_rs        <= '0;
      alu_rt        <= '0;
      alu_imm       <= '0;
      done          <= 1'b0;
      branch_valid  <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      illegal       <= 1'b0;
    end else begin
      done         <= 1'b0;
      branch_valid <= 1'b0;
      illegal      <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          instrQ <= instr;
          pcQ    <= instr_pc;
          state  <= READ;
        end
        READ: begin
          alu_opcode <= op;
          alu_rs     <= rsData;
          alu_rt     <= rtData;
          alu_imm    <= extendImm(op, imm);
          state      <= EXEC;
        end
        EXEC: begin
          resultQ <= alu_result;
          zeroQ   <= alu_zero;
          state   <= WB;
        end
        default: begin
          done    <= 1'b1;
          illegal <= !writesRt(op) && !isBranch(op);
          if (isBranch(op)) begin
            branch_valid  <= 1'b1;
            branch_taken  <= (op == OP_BEQ) ? zeroQ : !zeroQ;
            branch_target <= pcQ + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
          end
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef OVERFLOW_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflowQ <= 1'b0;
      trap      <= 1'b0;
    end else begin
      if (state == EXEC) overflowQ <= alu_overflow;
      trap <= (state == WB) && suppressWr;
    end
  end
`endif

endmodule

// File: tb/tb_itype_issue_unit.sv
// Scoreboard bench for itype_issue_unit with a behavioural ALU; directed vectors with hand-computed results.
module tb_itype_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_rs;
  logic [31:0] alu_rt;
  logic [31:0] alu_imm;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        done;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`ifdef OVERFLOW_TRAP_EN
  logic        trap;
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  itype_issue_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .alu_opcode    (alu_opcode),
    .alu_rs        (alu_rs),
    .alu_rt        (alu_rt),
    .alu_imm       (alu_imm),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .done          (done),
    .branch_valid  (branch_valid),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .illegal       (illegal),
`ifdef OVERFLOW_TRAP_EN
    .trap          (trap),
`endif
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  // Behavioural I-type ALU
  logic [31:0] sum;
  always_comb begin
    sum          = alu_rs + alu_imm;
    alu_result   = 32'h0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      6'b001000, 6'b001001: begin
        alu_result   = sum;
        alu_overflow = (alu_rs[31] == alu_imm[31]) && (sum[31] != alu_rs[31]);
      end
      6'b001010: alu_result = {31'h0, $signed(alu_rs) < $signed(alu_imm)};
      6'b001011: alu_result = {31'h0, alu_rs < alu_imm};
      6'b001100: alu_result = alu_rs & alu_imm;
      6'b001101: alu_result = alu_rs | alu_imm;
      6'b001111: alu_result = alu_imm;
      6'b000100, 6'b000101: alu_result = alu_rs - alu_rt;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  typedef struct {
    int          acc;
    logic        isBr;
    logic        taken;
    logic [31:0] tgt;
    logic        ill;
    logic [31:0] imm;
    logic [31:0] regVal;
    logic        trp;
  } expT;

  expT expQ[$];
  int  nChecks = 0;
  int  nFails  = 0;
  int  cyc     = 0;
  int  nDone   = 0;
  int  nIssued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        nDone++;
        if (expQ.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          expT e;
          e = expQ.pop_front();
          chk("done_latency", cyc, e.acc + 3);
          chk("alu_imm", alu_imm, e.imm);
          chk("branch_valid", {31'h0, branch_valid}, {31'h0, e.isBr});
          if (e.isBr) begin
            chk("branch_taken", {31'h0, branch_taken}, {31'h0, e.taken});
            chk("branch_target", branch_target, e.tgt);
          end
          chk("illegal", {31'h0, illegal}, {31'h0, e.ill});
          chk("rt_value", dbg_data, e.regVal);
`ifdef OVERFLOW_TRAP_EN
          chk("trap", {31'h0, trap}, {31'h0, e.trp});
`endif
        end
      end else if (branch_valid || illegal) begin
        chk("pulse_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic isBr,
                       input logic taken, input logic [31:0] tgt, input logic ill,
                       input logic [31:0] imm, input logic [31:0] regVal, input logic trp,
                       input bit hold);
    expT e;
    int  n;
    instr       = ins;
    instr_pc    = pc;
    dbg_addr    = ins[20:16];
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc = cyc; e.isBr = isBr; e.taken = taken; e.tgt = tgt; e.ill = ill;
    e.imm = imm; e.regVal = regVal; e.trp = trp;
    expQ.push_back(e);
    nIssued++;
    if (!hold) instr_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (hold && !done) chk("ready_low_while_busy", {31'h0, instr_ready}, 32'd0);
    end while (!done && n < 10);
    instr_valid = 1'b0;
    if (!done) chk("done_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; instr_pc = '0; dbg_addr = 5'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'h0, instr_ready}, 32'd1);
    chk("reset_done", {31'h0, done}, 32'd0);
    chk("reset_alu_imm", alu_imm, 32'h0);
    chk("reset_alu_rs", alu_rs, 32'h0);
    chk("reset_alu_opcode", {26'h0, alu_opcode}, 32'h0);
    chk("reset_reg1", dbg_data, 32'h0);

    //    instr         pc            br    tk    target        ill   imm           rt value      trap  hold
    issue(32'h2001FFFB, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFB, 32'hFFFFFFFB, 1'b0, 1'b0);
    issue(32'h302200F0, 32'h4,        1'b0, 1'b0, 32'h0,        1'b0, 32'h000000F0, 32'h000000F0, 1'b0, 1'b0);
    issue(32'h3C031234, 32'h8,        1'b0, 1'b0, 32'h0,        1'b0, 32'h12340000, 32'h12340000, 1'b0, 1'b0);
    issue(32'h10000003, 32'h100,      1'b1, 1'b1, 32'h110,      1'b0, 32'h00000003, 32'h0,        1'b0, 1'b0);
    issue(32'h14000003, 32'h100,      1'b1, 1'b0, 32'h110,      1'b0, 32'h00000003, 32'h0,        1'b0, 1'b0);
    issue(32'h1420FFFF, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0);
    issue(32'h10200004, 32'hFFFFFFF8, 1'b1, 1'b0, 32'h0000000C, 1'b0, 32'h00000004, 32'h0,        1'b0, 1'b0);
    issue(32'h20000007, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h00000007, 32'h0,        1'b0, 1'b0);
    issue(32'h00000000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h00000000, 32'h0,        1'b0, 1'b0);
    issue(32'h28250000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h00000000, 32'h00000001, 1'b0, 1'b0);
    issue(32'h2C250001, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
    issue(32'h20090010, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h00000010, 32'h00000010, 1'b0, 1'b1);
    issue(32'h3C047FFF, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h7FFF0000, 32'h7FFF0000, 1'b0, 1'b0);
    issue(32'h3484FFFF, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0000FFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
    issue(32'h20860001, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h00000001,
          TRAP_EN ? 32'h0 : 32'h80000000, TRAP_EN, 1'b0);
    issue(32'h24880001, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h00000001, 32'h80000000, 1'b0, 1'b0);

    dbg_addr = 5'd3;
    #1 chk("reg3_retained", dbg_data, 32'h12340000);

    // Abort ADDI $7,$0,1 with reset during EXEC
    dbg_addr = 5'd7;
    instr = 32'h20070001; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'h0, instr_ready}, 32'd1);
    chk("abort_alu_imm", alu_imm, 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", {31'h0, done}, 32'd0);
    end
    chk("abort_reg7", dbg_data, 32'h0);

    chk("done_count", nDone, nIssued);
    chk("queue_empty", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got no summary expected summary");
    $fatal(1);
  end

endmodule

// File: doc/itype_issue_unit.md
Name: itype_issue_unit

Overview:
Multi-cycle issue/writeback stage wrapped around the I-type ALU. It accepts one 32-bit MIPS I-type instruction at a time from fetch and decodes it. It reads operands from an internal 32x32 register file, extends the immediate per opcode, drives the ALU operand bus and captures the ALU outputs. It then writes back to rt, or reports the branch outcome for BEQ/BNE.

Parameters:
RESET_PC_UNUSED, none: no parameters; widths fixed at 32-bit data, 5-bit register index, 6-bit opcode.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  fetch presents instr/instr_pc
instr_ready  out  1  unit can accept; high only in IDLE
instr  in  32  instruction word: [31:26] op, [25:21] rs, [20:16] rt, [15:0] imm
instr_pc  in  32  address of instr
alu_opcode  out  6  opcode to ALU
alu_rs  out  32  rs register value
alu_rt  out  32  rt register value
alu_imm  out  32  extended immediate
alu_result  in  32  ALU result
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU signed-overflow flag
done  out  1  one-cycle pulse when an instruction retires
branch_valid  out  1  one-cycle pulse, retired instr was BEQ/BNE
branch_taken  out  1  valid with branch_valid
branch_target  out  32  instr_pc + 4 + (sext(imm) << 2), valid with branch_valid
illegal  out  1  one-cycle pulse, opcode not supported
dbg_addr  in  5  debug read address
dbg_data  out  32  combinational read of register dbg_addr

Behaviour:
- Reset is synchronous and active-high. While rst is high at a clock edge:
  - FSM goes to IDLE.
  - All 32 registers are cleared to 0.
  - All registered outputs are cleared to 0: alu_*, done, branch_*, illegal.
  - instr_ready is 1 from the first cycle after reset.
- Reset mid-operation aborts the instruction with no register write and no pulses.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch instr and instr_pc, then go to READ.
- READ:
  - Read rs and rt from the register file.
  - Register alu_opcode, alu_rs, alu_rt and alu_imm.
  - Go to EXEC.
- EXEC:
  - ALU is combinational.
  - Capture alu_result, alu_zero and alu_overflow at the end of the cycle.
  - Go to WB.
- WB:
  - Perform the register write if the opcode writes.
  - Pulse done, plus branch_valid or illegal as applicable.
  - Return to IDLE.
- Latency: done is high exactly 3 cycles after the accept edge. Throughput is 1 instruction per 4 cycles.
- instr_valid outside IDLE is ignored; fetch must hold its data until accepted.
- Immediate extension:
  - ADDI(001000), ADDIU(001001), SLTI(001010), SLTIU(001011), BEQ(000100), BNE(000101): sign-extend.
  - ANDI(001100), ORI(001101): zero-extend.
  - LUI(001111): {imm16, 16'h0000}. The ALU takes the upper half.
- Writeback:
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/LUI write alu_result to rt.
  - Writes to register 0 are discarded; register 0 always reads 0.
- Branches:
  - BEQ: branch_taken = alu_zero.
  - BNE: branch_taken = ~alu_zero.
  - Branches make no register write.
  - branch_target arithmetic is modulo 2^32 (wrap-around permitted).
- Any other opcode: illegal pulse in WB, no write, no branch_valid.
- Since instructions are strictly sequential, there is no hazard: a write in WB is visible to the next instruction's READ.
- dbg_data reflects the write from the cycle after WB.

Optional Feature:
OVERFLOW_TRAP_EN
- Defined: an ADDI with captured alu_overflow=1 suppresses the register write and pulses an extra output port trap (1 bit) in WB together with done.
- Undefined: the trap port does not exist, and an ADDI with overflow writes the wrapped sum normally. ADDIU never traps in either build.

Decomposition:
- Shared package itype_pkg holds:
  - the opcode constants (ADDI, ADDIU, ANDI, ORI, LUI, SLTI, SLTIU, BEQ, BNE)
  - the FSM state enum (IDLE, READ, EXEC, WB)
  - the field-position constants for op/rs/rt/imm
- One sub-module is natural: itype_regfile, 32x32, two combinational read ports plus debug read, one synchronous write port, synchronous reset to zero, register 0 hardwired to 0.

Test Plan:
- Reset, then ADDI $1,$0,-5 (0x2001FFFB) -> alu_imm=0xFFFFFFFB; done 3 cycles after accept; dbg_addr=1 reads 0xFFFFFFFB.
- ANDI $2,$1,0x00F0 (0x302200F0) -> alu_imm=0x000000F0 (zero-extended); reg2=0x000000F0. LUI $3,0x1234 (0x3C031234) -> alu_imm=0x12340000; reg3=0x12340000.
- BEQ $0,$0,+3 at pc 0x100 (0x10000003) -> branch_valid=1, branch_taken=1, branch_target=0x110, no register change. BNE $0,$0,+3 -> branch_taken=0, same target.
- ADDI $0,$0,7 -> reg0 reads 0. Instruction 0x00000000 -> illegal pulse, no write, no branch_valid. instr_valid held high during READ/EXEC/WB -> no second accept until IDLE.
- LUI $4,0x7FFF; ORI $4,$4,0xFFFF; ADDI $6,$4,1 -> alu_overflow=1.
  - With OVERFLOW_TRAP_EN: trap=1, reg6=0.
  - Without it: reg6=0x80000000.
- Assert rst during EXEC of ADDI $7,$0,1 -> next cycle IDLE, instr_ready=1, reg7=0, no done pulse.
